io_line_arbiter: RTL and testbench
==================================

IO_LINE_ARBITER -- requirements
Module: io_line_arbiter

Interface
REQ-001 Parameter BIT_CYCLES, default 4: clocks each serial bit is held on the line (>=1).
REQ-002 Parameter TURN_CYCLES, default 2: released-line clocks between drive and sample (>=1).
REQ-003 clk  in  1  single system clock; all logic on rising edge.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 req  in  2  per-requester transfer request; hold until matching gnt bit rises.
REQ-006 data0, data1  in  8 each  byte to send for requester 0 / 1; sampled on grant.
REQ-007 gnt  out  2  one-hot grant; high for the whole transfer.
REQ-008 busy  out  1  high while any state other than IDLE.
REQ-009 done  out  1  one-cycle end-of-transfer pulse.
REQ-010 ack  out  1  bit sampled from the line; valid with done, held until next done.
REQ-011 io_oe  out  1  pad drive enable; 0 = high impedance.
REQ-012 io_out  out  1  value driven when io_oe=1.
REQ-013 io_in  in  1  pad input value, already synchronised externally.

Function
REQ-014 States IDLE, SHIFT, TURN, SAMPLE; io_oe=1 only in SHIFT.
REQ-015 IDLE: if req!=0, grant one requester, latch its data, assert its gnt bit, enter SHIFT next cycle; io_oe rises the same edge.
REQ-016 Arbitration round-robin: prio bit selects the winner when both req bits are set; after a grant to k, prio = 1-k.
REQ-017 SHIFT: 8 bits MSB first, each held exactly BIT_CYCLES clocks; after bit 0 -> TURN.
REQ-018 TURN: io_oe=0, io_out=0 for exactly TURN_CYCLES clocks -> SAMPLE.
REQ-019 SAMPLE: io_oe=0 for BIT_CYCLES clocks; io_in captured on the last SAMPLE clock into ack; -> IDLE.
REQ-020 On the first IDLE cycle after SAMPLE: done=1, gnt=0, busy=0; arbitration also runs in that cycle, so back-to-back grants have zero gap.
REQ-021 Latency: req seen at edge N -> gnt/io_oe high from N+1 -> done high at N+1+8*BIT_CYCLES+TURN_CYCLES+BIT_CYCLES (N+39 with defaults).
REQ-022 Deasserting req during a transfer does not abort it; a req still high on the done cycle counts as a new request.
REQ-023 Changes to data0/data1 after the grant have no effect on the byte being sent.
REQ-024 io_oe and io_out are registered outputs; the two are never both changed from glitching combinational logic.
REQ-025 Counters: bit index 3 bits, cycle counter wide enough for max(BIT_CYCLES,TURN_CYCLES)-1; no wrap beyond terminal count.

Reset
REQ-026 On rst: state IDLE, io_oe=0, io_out=0, gnt=0, busy=0, done=0, ack=0, prio=0, counters 0.
REQ-027 rst during SHIFT releases the line on the next edge; no done pulse for the aborted transfer.

Structure
REQ-028 Shared package holds the state encoding and default BIT_CYCLES/TURN_CYCLES constants.
REQ-029 One sub-module, rr_arbiter2 (2-way round-robin with prio register); sequencer and shifter stay in io_line_arbiter.

Verification
REQ-030 req=01, data0=0xA5 -> gnt=01, io_out pattern 1,0,1,0,0,1,0,1, each 4 clocks, io_oe high 32 clocks.
REQ-031 Bench drives io_in=1 only while io_oe=0 -> ack=1 with done at grant+38; no cycle with io_oe=1 while bench drives.
REQ-032 req=11 after reset -> requester 0 first, requester 1 granted on the done cycle edge, then prio returns to 0.
REQ-033 rst asserted at bit 3 of SHIFT -> io_oe=0 next cycle, gnt=0, no done, next req=10 starts cleanly.
REQ-034 BIT_CYCLES=1, TURN_CYCLES=1, data1=0xFF -> done exactly 10 cycles after gnt rises.
REQ-035 data0 changed from 0x0F to 0xF0 one cycle after grant -> line still carries 0x0F.

Source files
------------

// File: rtl/io_line_arbiter_pkg.sv
// Shared definitions for the two-requester single-wire line arbiter.
// Holds the sequencer state encoding, default timing and a counter-width helper.
package io_line_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StTurn,
        StSample
    } state_e;

    localparam int unsigned DefBitCycles  = 4;
    localparam int unsigned DefTurnCycles = 2;

    // The counter only ever has to reach max_cycles-1.
    function automatic int unsigned cnt_width(input int unsigned max_cycles);
        return (max_cycles > 1) ? $clog2(max_cycles) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. The prio bit picks the winner on a tie and,
// once a grant is taken, moves to the requester that lost.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] gnt,
    output logic       valid
);

    logic prio_q, prio_d;
    logic [1:0] gnt_c;

    always_comb begin
        gnt_c = req;
        if (req == 2'b11) begin
            gnt_c = prio_q ? 2'b10 : 2'b01;
        end
    end

    // After a grant to requester k, prio becomes 1-k.
    always_comb begin
        prio_d = prio_q;
        if (update) begin
            prio_d = gnt_c[0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

    assign gnt   = gnt_c;
    assign valid = |req;

endmodule

// File: rtl/io_line_arbiter.sv
// Grants a shared bidirectional line to one of two requesters, shifts its byte
// out MSB first, releases the line, then samples a single reply bit.
module io_line_arbiter
    import io_line_arbiter_pkg::*;
#(
    parameter int unsigned BIT_CYCLES  = DefBitCycles,
    parameter int unsigned TURN_CYCLES = DefTurnCycles
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    output logic [1:0] gnt,
    output logic       busy,
    output logic       done,
    output logic       ack,
    output logic       io_oe,
    output logic       io_out,
    input  logic       io_in
);

    localparam int unsigned MaxCycles = (BIT_CYCLES > TURN_CYCLES) ? BIT_CYCLES : TURN_CYCLES;
    localparam int unsigned CntW      = cnt_width(MaxCycles);

    localparam logic [CntW-1:0] BitLast  = CntW'(BIT_CYCLES - 1);
    localparam logic [CntW-1:0] TurnLast = CntW'(TURN_CYCLES - 1);

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shreg_q, shreg_d;
    logic [1:0]      gnt_q, gnt_d;
    logic            io_oe_q, io_oe_d;
    logic            io_out_q, io_out_d;
    logic            done_q, done_d;
    logic            ack_q, ack_d;

    logic [1:0] arb_gnt;
    logic       arb_valid;
    logic       arb_update;
    logic [7:0] data_sel;

    rr_arbiter2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .update (arb_update),
        .gnt    (arb_gnt),
        .valid  (arb_valid)
    );

    assign data_sel = arb_gnt[1] ? data1 : data0;

    // Line outputs are computed for the next state so they leave a flop directly.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        shreg_d    = shreg_q;
        gnt_d      = gnt_q;
        io_oe_d    = 1'b0;
        io_out_d   = 1'b0;
        done_d     = 1'b0;
        ack_d      = ack_q;
        arb_update = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (arb_valid) begin
                    state_d    = StShift;
                    gnt_d      = arb_gnt;
                    shreg_d    = data_sel;
                    bit_idx_d  = 3'd7;
                    cnt_d      = '0;
                    io_oe_d    = 1'b1;
                    io_out_d   = data_sel[7];
                    arb_update = 1'b1;
                end
            end
            StShift: begin
                io_oe_d  = 1'b1;
                io_out_d = io_out_q;
                if (cnt_q == BitLast) begin
                    cnt_d = '0;
                    if (bit_idx_q == 3'd0) begin
                        state_d  = StTurn;
                        io_oe_d  = 1'b0;
                        io_out_d = 1'b0;
                    end else begin
                        bit_idx_d = bit_idx_q - 3'd1;
                        io_out_d  = shreg_q[bit_idx_q - 3'd1];
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StTurn: begin
                if (cnt_q == TurnLast) begin
                    cnt_d   = '0;
                    state_d = StSample;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StSample: begin
                if (cnt_q == BitLast) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                    done_d  = 1'b1;
                    ack_d   = io_in;
                    gnt_d   = 2'b00;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                gnt_d   = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            shreg_q   <= 8'h00;
            gnt_q     <= 2'b00;
            io_oe_q   <= 1'b0;
            io_out_q  <= 1'b0;
            done_q    <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            gnt_q     <= gnt_d;
            io_oe_q   <= io_oe_d;
            io_out_q  <= io_out_d;
            done_q    <= done_d;
            ack_q     <= ack_d;
        end
    end

    assign gnt    = gnt_q;
    assign busy   = (state_q != StIdle);
    assign done   = done_q;
    assign ack    = ack_q;
    assign io_oe  = io_oe_q;
    assign io_out = io_out_q;

endmodule

// File: tb/tb_io_line_arbiter.sv
// Bench for io_line_arbiter: a default-timing instance and a BIT_CYCLES=1/TURN_CYCLES=1
// instance, each tracked by a transfer-level model plus directed literal checks.
module tb_io_line_arbiter;

    localparam int BC0 = 4;
    localparam int TC0 = 2;
    localparam int BC1 = 1;
    localparam int TC1 = 1;

    logic clk;
    logic       rst_v  [2];
    logic [1:0] req_v  [2];
    logic [7:0] d0_v   [2];
    logic [7:0] d1_v   [2];
    logic [1:0] gnt_v  [2];
    logic       busy_v [2];
    logic       done_v [2];
    logic       ack_v  [2];
    logic       oe_v   [2];
    logic       out_v  [2];
    logic       in_v   [2];
    logic       resp   [2];

    int n_checks = 0;
    int n_fail   = 0;

    io_line_arbiter #(.BIT_CYCLES(BC0), .TURN_CYCLES(TC0)) u_dut0 (
        .clk    (clk),
        .rst    (rst_v[0]),
        .req    (req_v[0]),
        .data0  (d0_v[0]),
        .data1  (d1_v[0]),
        .gnt    (gnt_v[0]),
        .busy   (busy_v[0]),
        .done   (done_v[0]),
        .ack    (ack_v[0]),
        .io_oe  (oe_v[0]),
        .io_out (out_v[0]),
        .io_in  (in_v[0])
    );

    io_line_arbiter #(.BIT_CYCLES(BC1), .TURN_CYCLES(TC1)) u_dut1 (
        .clk    (clk),
        .rst    (rst_v[1]),
        .req    (req_v[1]),
        .data0  (d0_v[1]),
        .data1  (d1_v[1]),
        .gnt    (gnt_v[1]),
        .busy   (busy_v[1]),
        .done   (done_v[1]),
        .ack    (ack_v[1]),
        .io_oe  (oe_v[1]),
        .io_out (out_v[1]),
        .io_in  (in_v[1])
    );

    // Pad model: DUT drives when enabled; the responder only drives during a granted,
    // released-line window; otherwise the line is pulled low.
    assign in_v[0] = oe_v[0] ? out_v[0] : ((gnt_v[0] != 2'b00) ? resp[0] : 1'b0);
    assign in_v[1] = oe_v[1] ? out_v[1] : ((gnt_v[1] != 2'b00) ? resp[1] : 1'b0);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transfer-level model: a transfer is a count of elapsed cycles from the grant.
    bit         m_act  [2];
    int         m_t    [2];
    int         m_k    [2];
    logic [7:0] m_byte [2];
    int         m_prio [2];
    bit         m_done [2];
    logic       m_ack  [2];

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_act[i] = 0; m_t[i] = 0; m_k[i] = 0; m_byte[i] = 8'h00;
            m_prio[i] = 0; m_done[i] = 0; m_ack[i] = 1'b0;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int bc, tc, len, k;
            bit nd;
            logic       e_oe, e_out;
            logic [1:0] e_gnt;
            bc  = (i == 0) ? BC0 : BC1;
            tc  = (i == 0) ? TC0 : TC1;
            len = 9 * bc + tc;
            e_oe  = m_act[i] && (m_t[i] < 8 * bc);
            e_out = e_oe ? m_byte[i][7 - m_t[i] / bc] : 1'b0;
            e_gnt = m_act[i] ? ((m_k[i] == 1) ? 2'b10 : 2'b01) : 2'b00;
            check($sformatf("i%0d gnt", i), 32'(gnt_v[i]), 32'(e_gnt));
            check($sformatf("i%0d busy", i), 32'(busy_v[i]), 32'(m_act[i]));
            check($sformatf("i%0d io_oe", i), 32'(oe_v[i]), 32'(e_oe));
            check($sformatf("i%0d io_out", i), 32'(out_v[i]), 32'(e_out));
            check($sformatf("i%0d done", i), 32'(done_v[i]), 32'(m_done[i]));
            check($sformatf("i%0d ack", i), 32'(ack_v[i]), 32'(m_ack[i]));
            // Advance to what the next edge produces.
            if (rst_v[i]) begin
                m_act[i] = 0; m_t[i] = 0; m_k[i] = 0; m_byte[i] = 8'h00;
                m_prio[i] = 0; m_done[i] = 0; m_ack[i] = 1'b0;
            end else begin
                nd = 0;
                if (m_act[i]) begin
                    if (m_t[i] == len - 1) begin
                        m_act[i] = 0;
                        nd       = 1;
                        m_ack[i] = in_v[i];
                    end else begin
                        m_t[i]++;
                    end
                end else if (req_v[i] != 2'b00) begin
                    if (req_v[i] == 2'b11) k = m_prio[i];
                    else k = req_v[i][1] ? 1 : 0;
                    m_act[i]  = 1;
                    m_t[i]    = 0;
                    m_k[i]    = k;
                    m_byte[i] = (k == 1) ? d1_v[i] : d0_v[i];
                    m_prio[i] = 1 - k;
                end
                m_done[i] = nd;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in the grant cycle; returns in the done cycle (or after the bound).
    task automatic run_to_done(input int i, input int bc, input int bound,
                               output int done_at, output logic [7:0] got, output int oec);
        done_at = -1;
        got     = 8'h00;
        oec     = 0;
        for (int c = 0; c < bound; c++) begin
            if (done_v[i]) begin
                done_at = c;
                break;
            end
            if (oe_v[i]) oec++;
            if (c < 8 * bc && (c % bc) == 0) got = {got[6:0], out_v[i]};
            tick();
        end
    endtask

    initial begin
        int         da, oec, nd;
        logic [7:0] got;
        for (int i = 0; i < 2; i++) begin
            rst_v[i] = 1'b1; req_v[i] = 2'b00; d0_v[i] = 8'h00; d1_v[i] = 8'h00; resp[i] = 1'b0;
        end
        tick();
        tick();
        check("reset gnt", 32'(gnt_v[0]), 32'h0);
        check("reset busy", 32'(busy_v[0]), 32'h0);
        check("reset io_oe", 32'(oe_v[0]), 32'h0);
        check("reset io_out", 32'(out_v[0]), 32'h0);
        check("reset done", 32'(done_v[0]), 32'h0);
        check("reset ack", 32'(ack_v[0]), 32'h0);
        rst_v[0] = 1'b0;
        rst_v[1] = 1'b0;

        // Single transfer of 0xA5 from requester 0, responder answers 1.
        d0_v[0] = 8'hA5; resp[0] = 1'b1; req_v[0] = 2'b01;
        tick();
        check("a5 gnt", 32'(gnt_v[0]), 32'h1);
        check("a5 io_oe", 32'(oe_v[0]), 32'h1);
        req_v[0] = 2'b00;
        run_to_done(0, BC0, 80, da, got, oec);
        check("a5 done latency", 32'(da), 32'd38);
        check("a5 line byte", 32'(got), 32'hA5);
        check("a5 oe cycles", 32'(oec), 32'd32);
        check("a5 ack", 32'(ack_v[0]), 32'h1);
        check("a5 done gnt", 32'(gnt_v[0]), 32'h0);
        check("a5 done busy", 32'(busy_v[0]), 32'h0);

        // Both requesting after reset: 0 first, then 1 straight off the done cycle.
        rst_v[0] = 1'b1;
        tick();
        rst_v[0] = 1'b0;
        d0_v[0] = 8'h3C; d1_v[0] = 8'hC3; resp[0] = 1'b0; req_v[0] = 2'b11;
        tick();
        check("rr first gnt", 32'(gnt_v[0]), 32'h1);
        run_to_done(0, BC0, 80, da, got, oec);
        check("rr first byte", 32'(got), 32'h3C);
        check("rr done gnt", 32'(gnt_v[0]), 32'h0);
        tick();
        check("rr second gnt", 32'(gnt_v[0]), 32'h2);
        req_v[0] = 2'b00;
        run_to_done(0, BC0, 80, da, got, oec);
        check("rr second byte", 32'(got), 32'hC3);
        check("rr second ack", 32'(ack_v[0]), 32'h0);
        req_v[0] = 2'b11;
        tick();
        check("rr prio back to 0", 32'(gnt_v[0]), 32'h1);
        req_v[0] = 2'b00;

        // Reset in the middle of bit 3.
        repeat (17) tick();
        rst_v[0] = 1'b1;
        tick();
        check("abort io_oe", 32'(oe_v[0]), 32'h0);
        check("abort gnt", 32'(gnt_v[0]), 32'h0);
        check("abort busy", 32'(busy_v[0]), 32'h0);
        rst_v[0] = 1'b0;
        nd = 0;
        for (int c = 0; c < 45; c++) begin
            if (done_v[0]) nd++;
            tick();
        end
        check("abort no done", 32'(nd), 32'd0);
        d1_v[0] = 8'h81; resp[0] = 1'b1; req_v[0] = 2'b10;
        tick();
        check("restart gnt", 32'(gnt_v[0]), 32'h2);
        req_v[0] = 2'b00;
        run_to_done(0, BC0, 80, da, got, oec);
        check("restart latency", 32'(da), 32'd38);
        check("restart byte", 32'(got), 32'h81);
        check("restart ack", 32'(ack_v[0]), 32'h1);

        // Data changed right after the grant must not reach the line.
        d0_v[0] = 8'h0F; req_v[0] = 2'b01;
        tick();
        check("latch gnt", 32'(gnt_v[0]), 32'h1);
        req_v[0] = 2'b00;
        d0_v[0] = 8'hF0;
        run_to_done(0, BC0, 80, da, got, oec);
        check("latch byte", 32'(got), 32'h0F);

        // Minimal timing instance.
        d1_v[1] = 8'hFF; resp[1] = 1'b1; req_v[1] = 2'b10;
        tick();
        check("fast gnt", 32'(gnt_v[1]), 32'h2);
        req_v[1] = 2'b00;
        run_to_done(1, BC1, 40, da, got, oec);
        check("fast latency", 32'(da), 32'd10);
        check("fast byte", 32'(got), 32'hFF);
        check("fast oe cycles", 32'(oec), 32'd8);
        check("fast ack", 32'(ack_v[1]), 32'h1);
        d0_v[1] = 8'h5A; resp[1] = 1'b0; req_v[1] = 2'b11;
        tick();
        check("fast b2b first", 32'(gnt_v[1]), 32'h1);
        run_to_done(1, BC1, 40, da, got, oec);
        check("fast b2b byte", 32'(got), 32'h5A);
        tick();
        check("fast b2b second", 32'(gnt_v[1]), 32'h2);
        req_v[1] = 2'b00;
        run_to_done(1, BC1, 40, da, got, oec);
        check("fast b2b latency", 32'(da), 32'd10);
        check("fast b2b ack", 32'(ack_v[1]), 32'h0);
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

endmodule
